// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped down-counting timer with level interrupt
// Optional prescaler compiled in by defining MMIO_TIMER_PRESCALE_EN.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        mmu_mmio_read,
  input  logic        mmu_mmio_write,
  input  logic [31:0] mmu_mmio_addr,
  input  logic [31:0] mmu_mmio_wdata,
  output logic        mmu_mmio_hit,
  output logic [31:0] mmu_mmio_data,
  output logic        timer_irq
);

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_LOAD     = 3'd1;
  localparam logic [2:0] IDX_COUNT    = 3'd2;
  localparam logic [2:0] IDX_STATUS   = 3'd3;
`ifdef MMIO_TIMER_PRESCALE_EN
  localparam logic [2:0] IDX_PRESCALE = 3'd4;
`endif

  // ctrl_q = {IE, AUTO, EN}
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
`ifdef MMIO_TIMER_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        wr_prescale;
`endif

  logic       in_window;
  logic [2:0] reg_idx;
  logic       mapped;
  logic       wr_ctrl, wr_load, wr_count, wr_status;
  logic       en_clear;
  logic       tick;
  logic       expire;
  logic       unused_addr_bits;

  // Byte lanes within a word are not decoded; the window is 32 bytes wide.
  assign unused_addr_bits = ^mmu_mmio_addr[1:0];
  assign in_window = (mmu_mmio_addr[31:5] == BASE_ADDR[31:5]);
  assign reg_idx   = mmu_mmio_addr[4:2];

  // Address decode: hit only for a mapped register while a strobe is up.
  always_comb begin
    mapped = (reg_idx[2] == 1'b0);
`ifdef MMIO_TIMER_PRESCALE_EN
    if (reg_idx == IDX_PRESCALE) mapped = 1'b1;
`endif
    mmu_mmio_hit = (mmu_mmio_read | mmu_mmio_write) & in_window & mapped;
  end

  // Read mux returns pre-edge register state; zero unless a read hits.
  always_comb begin
    mmu_mmio_data = 32'h0;
    if (mmu_mmio_hit && mmu_mmio_read) begin
      case (reg_idx)
        IDX_CTRL:     mmu_mmio_data = {29'h0, ctrl_q};
        IDX_LOAD:     mmu_mmio_data = load_q;
        IDX_COUNT:    mmu_mmio_data = count_q;
        IDX_STATUS:   mmu_mmio_data = {31'h0, pend_q};
`ifdef MMIO_TIMER_PRESCALE_EN
        IDX_PRESCALE: mmu_mmio_data = {16'h0, prescale_q};
`endif
        default:      mmu_mmio_data = 32'h0;
      endcase
    end
  end

  assign timer_irq = pend_q & ctrl_q[2];

  // Next-state: timer tick first, then register writes override, set-wins on PEND.
  always_comb begin
    wr_ctrl   = mmu_mmio_write & mmu_mmio_hit & (reg_idx == IDX_CTRL);
    wr_load   = mmu_mmio_write & mmu_mmio_hit & (reg_idx == IDX_LOAD);
    wr_count  = mmu_mmio_write & mmu_mmio_hit & (reg_idx == IDX_COUNT);
    wr_status = mmu_mmio_write & mmu_mmio_hit & (reg_idx == IDX_STATUS);
    en_clear  = wr_ctrl & ~mmu_mmio_wdata[0];

    tick = ctrl_q[0] & ~en_clear;
`ifdef MMIO_TIMER_PRESCALE_EN
    wr_prescale = mmu_mmio_write & mmu_mmio_hit & (reg_idx == IDX_PRESCALE);
    tick = tick & (pcnt_q == prescale_q);
`endif
    expire = tick & (count_q == 32'h0);

    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    pend_d  = pend_q;

    if (tick) begin
      if (!expire)        count_d = count_q - 32'd1;
      else if (ctrl_q[1]) count_d = load_q;
    end
    if (expire && !ctrl_q[1]) ctrl_d[0] = 1'b0;

    if (wr_ctrl)  ctrl_d  = mmu_mmio_wdata[2:0];
    if (wr_load)  load_d  = mmu_mmio_wdata;
    if (wr_count) count_d = mmu_mmio_wdata;
    if (wr_status && mmu_mmio_wdata[0]) pend_d = 1'b0;
    if (expire) pend_d = 1'b1;

`ifdef MMIO_TIMER_PRESCALE_EN
    prescale_d = prescale_q;
    if (wr_prescale) prescale_d = mmu_mmio_wdata[15:0];
    if (!ctrl_q[0] || en_clear || wr_prescale) pcnt_d = 16'h0;
    else if (pcnt_q == prescale_q)             pcnt_d = 16'h0;
    else                                       pcnt_d = pcnt_q + 16'd1;
`endif
  end

  // State registers with synchronous reset that overrides any coincident access.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ctrl_q     <= 3'h0;
      load_q     <= 32'h0;
      count_q    <= 32'h0;
      pend_q     <= 1'b0;
`ifdef MMIO_TIMER_PRESCALE_EN
      prescale_q <= 16'h0;
      pcnt_q     <= 16'h0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
`ifdef MMIO_TIMER_PRESCALE_EN
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - self-checking bench for mmio_timer
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0100;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .mmu_mmio_read(rd), .mmu_mmio_write(wr),
    .mmu_mmio_addr(addr), .mmu_mmio_wdata(wdata),
    .mmu_mmio_hit(hit), .mmu_mmio_data(rdata), .timer_irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: register contents as plain variables
  logic [2:0]  m_ctrl = 3'h0;
  logic [31:0] m_load = 32'h0;
  logic [31:0] m_count = 32'h0;
  logic        m_pend = 1'b0;
  logic [15:0] m_prescale = 16'h0;
  int          m_phase = 0;

`ifdef MMIO_TIMER_PRESCALE_EN
  localparam int LAST_IDX = 4;
`else
  localparam int LAST_IDX = 3;
`endif

  function automatic int m_index(input logic [31:0] a);
    if (a < BASE || (a - BASE) >= 32) return -1;
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic m_hit(input logic r, input logic w, input logic [31:0] a);
    int i;
    i = m_index(a);
    return (r || w) && i >= 0 && i <= LAST_IDX;
  endfunction

  function automatic logic [31:0] m_data(input logic r, input logic w, input logic [31:0] a);
    if (!m_hit(r, w, a) || !r) return 32'h0;
    case (m_index(a))
      0: return {29'h0, m_ctrl};
      1: return m_load;
      2: return m_count;
      3: return {31'h0, m_pend};
      default: return {16'h0, m_prescale};
    endcase
  endfunction

  // Model advances one clock: what the timer does this cycle, then what the bus writes.
  always @(posedge sys_clk) begin : model
    int          idx;
    bit          w_ok, ctrl_off, ticks, expired;
    logic [2:0]  n_ctrl;
    logic [31:0] n_count;
    logic        n_pend;
    if (rst) begin
      m_ctrl = 0; m_load = 0; m_count = 0; m_pend = 0; m_prescale = 0; m_phase = 0;
    end else begin
      idx      = m_index(addr);
      w_ok     = wr && m_hit(rd, wr, addr);
      ctrl_off = w_ok && idx == 0 && !wdata[0];
      ticks    = m_ctrl[0] && !ctrl_off && (m_phase == int'(m_prescale));
      expired  = ticks && m_count == 0;
      n_ctrl = m_ctrl; n_count = m_count; n_pend = m_pend;
      if (ticks && m_count > 0) n_count = m_count - 1;
      if (expired) begin
        n_pend = 1;
        if (m_ctrl[1]) n_count = m_load;
        else n_ctrl[0] = 0;
      end
      if (!m_ctrl[0] || ctrl_off || (w_ok && idx == 4) || m_phase == int'(m_prescale)) m_phase = 0;
      else m_phase = m_phase + 1;
      if (w_ok) begin
        case (idx)
          0: n_ctrl = wdata[2:0];
          1: m_load = wdata;
          2: n_count = wdata;
          3: if (wdata[0]) n_pend = expired;
          default: m_prescale = wdata[15:0];
        endcase
      end
      m_ctrl = n_ctrl; m_count = n_count; m_pend = n_pend;
    end
  end

  // Every cycle: bus outputs and interrupt must match the model.
  always @(negedge sys_clk) begin
    if (chk_on) begin
      check("hit", {31'h0, hit}, {31'h0, m_hit(rd, wr, addr)});
      check("rdata", rdata, m_data(rd, wr, addr));
      check("irq", {31'h0, irq}, {31'h0, m_pend & m_ctrl[2]});
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
  endtask

  task automatic idle(input int n);
    drive(0, 0, BASE, 0);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic wreg(input logic [4:0] off, input logic [31:0] d);
    drive(0, 1, BASE + {27'h0, off}, d);
    @(posedge sys_clk); #1;
    drive(0, 0, BASE, 0);
  endtask

  task automatic rd_raw(input logic [31:0] a, input logic ehit, input logic [31:0] edata, input string name);
    drive(1, 0, a, 0);
    @(negedge sys_clk); #1;
    check({name, ".hit"}, {31'h0, hit}, {31'h0, ehit});
    check({name, ".data"}, rdata, edata);
    @(posedge sys_clk); #1;
    drive(0, 0, BASE, 0);
  endtask

  task automatic rd_chk(input logic [4:0] off, input logic [31:0] exp, input string name);
    drive(1, 0, BASE + {27'h0, off}, 0);
    @(negedge sys_clk); #1;
    check(name, rdata, exp);
    @(posedge sys_clk); #1;
    drive(0, 0, BASE, 0);
  endtask

  task automatic rw_chk(input logic [4:0] off, input logic [31:0] d, input logic [31:0] exp, input string name);
    drive(1, 1, BASE + {27'h0, off}, d);
    @(negedge sys_clk); #1;
    check(name, rdata, exp);
    @(posedge sys_clk); #1;
    drive(0, 0, BASE, 0);
  endtask

  task automatic irq_chk(input logic exp, input string name);
    check(name, {31'h0, irq}, {31'h0, exp});
  endtask

  initial begin
    rst = 1;
    @(posedge sys_clk); #1;
    chk_on = 1;
    repeat (2) begin @(posedge sys_clk); #1; end
    rst = 0;

    rd_chk(5'h00, 32'h0, "reset_ctrl");
    rd_chk(5'h08, 32'h0, "reset_count");
    rd_chk(5'h0C, 32'h0, "reset_status");
    irq_chk(0, "reset_irq");

    // Auto-reload with interrupt enabled
    wreg(5'h04, 3);
    wreg(5'h08, 3);
    wreg(5'h00, 7);
    rd_chk(5'h08, 3, "auto_c0");
    rd_chk(5'h08, 2, "auto_c1");
    rd_chk(5'h08, 1, "auto_c2");
    rd_chk(5'h08, 0, "auto_c3");
    rd_chk(5'h08, 3, "auto_reload");
    irq_chk(1, "auto_irq");
    rd_chk(5'h0C, 1, "auto_pend");
    wreg(5'h00, 0);
    wreg(5'h0C, 1);
    irq_chk(0, "w1c_irq");
    rd_chk(5'h0C, 0, "w1c_pend");

    // One-shot without interrupt enable
    wreg(5'h08, 2);
    wreg(5'h00, 1);
    idle(3);
    rd_chk(5'h00, 0, "oneshot_ctrl");
    rd_chk(5'h08, 0, "oneshot_count");
    rd_chk(5'h0C, 1, "oneshot_pend");
    irq_chk(0, "oneshot_irq");
    wreg(5'h0C, 1);

    // Decode boundaries
    wreg(5'h08, 32'hA5A5_0F0F);
    rd_raw(BASE + 32'h14, 0, 0, "unmapped_14");
    rd_raw(BASE - 32'h4, 0, 0, "below_base");
    rd_raw(BASE + 32'h40, 0, 0, "above_window");
    rd_raw(BASE + 32'h0B, 1, 32'hA5A5_0F0F, "count_byte_b");
`ifdef MMIO_TIMER_PRESCALE_EN
    rd_raw(BASE + 32'h10, 1, 0, "prescale_reset");
`else
    rd_raw(BASE + 32'h10, 0, 0, "no_prescale");
`endif

    // Clear racing an expiry, then read+write on STATUS
    wreg(5'h04, 3);
    wreg(5'h08, 0);
    wreg(5'h00, 7);
    idle(4);
    wreg(5'h0C, 1);
    rw_chk(5'h0C, 1, 1, "set_wins_pend");
    irq_chk(0, "cleared_irq");
    rd_chk(5'h0C, 0, "cleared_pend");
    wreg(5'h00, 0);

    // COUNT write overrides a tick
    wreg(5'h08, 10);
    wreg(5'h00, 1);
    wreg(5'h08, 100);
    rd_chk(5'h08, 100, "override_100");
    rd_chk(5'h08, 99, "override_99");

    // Reset mid-count coincident with a write
    wreg(5'h08, 1);
    wreg(5'h00, 7);
    idle(2);
    irq_chk(1, "prereset_irq");
    rst = 1;
    drive(0, 1, BASE, 7);
    @(posedge sys_clk); #1;
    rst = 0;
    drive(0, 0, BASE, 0);
    irq_chk(0, "postreset_irq");
    rd_chk(5'h00, 0, "postreset_ctrl");
    rd_chk(5'h04, 0, "postreset_load");
    rd_chk(5'h08, 0, "postreset_count");
    rd_chk(5'h0C, 0, "postreset_status");

`ifdef MMIO_TIMER_PRESCALE_EN
    wreg(5'h10, 2);
    wreg(5'h08, 1);
    wreg(5'h00, 1);
    rd_chk(5'h08, 1, "pre_c0");
    rd_chk(5'h08, 1, "pre_c1");
    rd_chk(5'h08, 1, "pre_c2");
    rd_chk(5'h08, 0, "pre_c3");
    rd_chk(5'h0C, 0, "pre_s4");
    rd_chk(5'h0C, 0, "pre_s5");
    rd_chk(5'h0C, 1, "pre_s6");
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_0100, byte base of the register window, 32-byte aligned.
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mmu_mmio_read  input  1  single-cycle read strobe from the MMU.
REQ-005 mmu_mmio_write  input  1  single-cycle write strobe from the MMU.
REQ-006 mmu_mmio_addr  input  32  byte address of the access.
REQ-007 mmu_mmio_wdata  input  32  write data, valid with mmu_mmio_write.
REQ-008 mmu_mmio_hit  output  1  address decodes to a mapped register of this device while a strobe is high.
REQ-009 mmu_mmio_data  output  32  read data, valid when mmu_mmio_hit and mmu_mmio_read are high.
REQ-010 timer_irq  output  1  level interrupt request.

Function
REQ-011 Register map (offset = addr - BASE_ADDR, addr[1:0] ignored): 0x00 CTRL {bit0 EN, bit1 AUTO, bit2 IE}; 0x04 LOAD; 0x08 COUNT; 0x0C STATUS {bit0 PEND}; all other bits read 0.
REQ-012 mmu_mmio_hit and mmu_mmio_data are combinational in the request cycle: zero latency, no wait states.
REQ-013 mmu_mmio_hit is 0 when no strobe is high, when the address is outside the window, or when the offset is unmapped.
REQ-014 mmu_mmio_data is 32'h0 whenever mmu_mmio_hit is 0 or mmu_mmio_read is 0.
REQ-015 Writes commit at the rising edge that ends the strobe cycle; reads return pre-edge register values.
REQ-016 Read and write strobes asserted together: the write executes, mmu_mmio_hit follows the address decode, and read data shows the pre-write value.
REQ-017 A tick occurs every cycle while EN=1 (see REQ-027 for the prescaled case).
REQ-018 On a tick with COUNT!=0: COUNT decrements by 1.
REQ-019 On a tick with COUNT==0: PEND<=1. If AUTO=1, COUNT<=LOAD and EN stays 1. If AUTO=0, EN<=0 and COUNT stays 0.
REQ-020 A write to COUNT in the same cycle as a tick overrides the decrement or reload; a write to CTRL clearing EN suppresses that cycle's tick.
REQ-021 A write to LOAD never alters COUNT.
REQ-022 STATUS is write-1-to-clear on bit0; an expiry in the same cycle as a W1C leaves PEND=1 (set wins).
REQ-023 timer_irq = PEND & IE, driven combinationally from registered state.

Reset
REQ-024 While rst=1 at a clock edge: CTRL<=0, LOAD<=0, COUNT<=0, PEND<=0 (and PRESCALE/prescale counter<=0 when compiled in); strobes are ignored.
REQ-025 Reset takes effect at the next edge, even mid-count or coincident with a write; timer_irq is 0 in the following cycle.

Configuration
REQ-026 Macro MMIO_TIMER_PRESCALE_EN selects the prescaler feature.
REQ-027 Defined: register PRESCALE[15:0] at offset 0x10, plus an internal prescale counter. While EN=1, a tick occurs when the counter equals PRESCALE, after which the counter clears; otherwise the counter increments. Ticks therefore fall every PRESCALE+1 cycles. Clearing EN or writing PRESCALE clears the counter.
REQ-028 Undefined: offset 0x10 is unmapped (hit=0) and a tick occurs every cycle while EN=1.

Verification
REQ-029 Write LOAD=3, COUNT=3, CTRL=0x7 -> COUNT reads 2,1,0 on successive cycles; PEND and timer_irq go to 1 on the fourth tick; COUNT reloads to 3.
REQ-030 COUNT=2, CTRL=0x1 (one-shot) -> after 3 ticks PEND=1, CTRL reads 0x0, COUNT holds 0, timer_irq stays 0 because IE=0.
REQ-031 Read of BASE_ADDR+0x14, of BASE_ADDR-4 and of BASE_ADDR+0x40 -> mmu_mmio_hit=0 and mmu_mmio_data=0. Read of BASE_ADDR+0x0B -> hit=1 with COUNT returned.
REQ-032 PEND=1 with W1C to STATUS in the same cycle as a new expiry -> PEND stays 1. W1C one cycle later -> PEND=0 and timer_irq=0 on the next cycle.
REQ-033 Write COUNT=100 in the same cycle as a tick -> COUNT reads 100 next cycle, then 99. Assert rst mid-count -> all registers read 0 afterwards.
REQ-034 With MMIO_TIMER_PRESCALE_EN: PRESCALE=2, COUNT=1, CTRL=0x1 -> COUNT reaches 0 after 3 cycles and PEND sets 3 cycles later. Without the macro: a read of offset 0x10 returns hit=0.
